sccb_cfg_seq: RTL

Parametrised SCCB/I2C register-write sequencer for the camera front end. It walks an external register table and writes each `{SLAVE_ADDR, reg, value}` triple to the sensor. It supports in-table millisecond delays, an early end marker, NACK detection with error reporting, and software-triggered re-configuration. It sits between the camera init ROM and the sensor's SCL/SDA pins; the pad tristate lives at top level.

---
 rtl/sccb_cfg_seq_pkg.sv | 28 ++
 rtl/sccb_cfg_seq_bit_engine.sv | 141 ++++++++++++++
 rtl/sccb_cfg_seq.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/sccb_cfg_seq_pkg.sv
// Shared types and constants for the SCCB configuration sequencer.
// Holds the sequencer state enum, bus phase enum and table marker values.
package sccb_cfg_pkg;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_START, S_XFER,
        S_STOP, S_GAP, S_DELAY, S_DONE, S_ERROR
    } seq_state_t;

    typedef enum logic [2:0] {
        PH_IDLE, PH_START, PH_XFER, PH_STOP, PH_GAP
    } phase_t;

    localparam logic [15:0] END_MARK  = 16'hFFFF;
    localparam logic [7:0]  DELAY_TAG = 8'hFF;
    localparam logic [1:0]  QTR_LAST  = 2'd3;
    localparam int          XFER_BITS = 27;
    localparam logic [4:0]  LAST_BIT  = 5'(XFER_BITS - 1);
    localparam logic [26:0] ACK_MASK  = {8'h00, 1'b1, 8'h00, 1'b1, 8'h00, 1'b1};

    // Ack slots carry a 1 so the master releases SDA there.
    function automatic logic [26:0] build_frame(input logic [7:0] addr,
                                                input logic [7:0] rg,
                                                input logic [7:0] val);
        return {addr, 1'b1, rg, 1'b1, val, 1'b1};
    endfunction

endpackage

// File: rtl/sccb_cfg_seq_bit_engine.sv
// SCCB bit engine: quarter-bit divider, START/27-bit/STOP/GAP waveform, ACK sampling.
// One go pulse runs a full write; done pulses on the last GAP tick with nack valid.
module sccb_bit_engine
    import sccb_cfg_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 25_000_000,
    parameter int unsigned I2C_FREQ = 100_000
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic       go_i,
    input  logic [7:0] addr_i,
    input  logic [7:0] reg_i,
    input  logic [7:0] val_i,
    input  logic       sda_i,
    output logic       scl_o,
    output logic       sda_oe_o,
    output phase_t     phase_o,
    output logic       done_o,
    output logic       nack_o
);

    localparam int unsigned Q_RAW    = CLK_FREQ / (4 * I2C_FREQ);
    localparam int unsigned Q        = (Q_RAW < 1) ? 1 : Q_RAW;
    localparam logic [31:0] DIV_LOAD = 32'(Q - 1);

    phase_t      phase_q, phase_d;
    logic [31:0] div_q, div_d;
    logic [1:0]  qtr_q, qtr_d;
    logic [4:0]  bit_q, bit_d;
    logic [26:0] sh_q, sh_d;
    logic [26:0] mask_q, mask_d;
    logic        nack_q, nack_d;
    logic        scl_q, scl_d;
    logic        oe_q, oe_d;
    logic [1:0]  sda_sync_q;
    logic        tick;
    logic        accept;

    assign tick     = (phase_q != PH_IDLE) && (div_q == 32'd0);
    assign done_o   = (phase_q == PH_GAP) && tick && (qtr_q == QTR_LAST);
    assign accept   = go_i && ((phase_q == PH_IDLE) || done_o);
    assign scl_o    = scl_q;
    assign sda_oe_o = oe_q;
    assign phase_o  = phase_q;
    assign nack_o   = nack_q;

    always_comb begin
        phase_d = phase_q;
        qtr_d   = qtr_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        mask_d  = mask_q;
        nack_d  = nack_q;
        scl_d   = scl_q;
        oe_d    = oe_q;
        if (phase_q == PH_IDLE || div_q == 32'd0) div_d = DIV_LOAD;
        else                                      div_d = div_q - 32'd1;

        if (tick) begin
            qtr_d = qtr_q + 2'd1;
            case (phase_q)
                PH_START: begin
                    if (qtr_q == 2'd1) oe_d = 1'b1;
                    if (qtr_q == QTR_LAST) begin
                        scl_d   = 1'b0;
                        phase_d = PH_XFER;
                    end
                end
                PH_XFER: begin
                    case (qtr_q)
                        2'd0: begin
                            oe_d  = ~sh_q[26];
                            scl_d = 1'b0;
                        end
                        2'd1: scl_d = 1'b1;
                        2'd2: if (mask_q[26] && sda_sync_q[1]) nack_d = 1'b1;
                        default: begin
                            scl_d  = 1'b0;
                            sh_d   = {sh_q[25:0], 1'b0};
                            mask_d = {mask_q[25:0], 1'b0};
                            if (bit_q == LAST_BIT) phase_d = PH_STOP;
                            else                   bit_d   = bit_q + 5'd1;
                        end
                    endcase
                end
                PH_STOP: begin
                    case (qtr_q)
                        2'd0: begin
                            oe_d  = 1'b1;
                            scl_d = 1'b0;
                        end
                        2'd1: scl_d = 1'b1;
                        2'd2: oe_d = 1'b0;
                        default: phase_d = PH_GAP;
                    endcase
                end
                PH_GAP: if (qtr_q == QTR_LAST) phase_d = PH_IDLE;
                default: phase_d = PH_IDLE;
            endcase
        end

        // A go arriving on the final GAP tick chains straight into the next START.
        if (accept) begin
            phase_d = PH_START;
            div_d   = DIV_LOAD;
            qtr_d   = 2'd0;
            bit_d   = 5'd0;
            sh_d    = build_frame(addr_i, reg_i, val_i);
            mask_d  = ACK_MASK;
            nack_d  = 1'b0;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            phase_q    <= PH_IDLE;
            div_q      <= DIV_LOAD;
            qtr_q      <= 2'd0;
            bit_q      <= 5'd0;
            sh_q       <= '0;
            mask_q     <= '0;
            nack_q     <= 1'b0;
            scl_q      <= 1'b1;
            oe_q       <= 1'b0;
            sda_sync_q <= 2'b11;
        end else begin
            phase_q    <= phase_d;
            div_q      <= div_d;
            qtr_q      <= qtr_d;
            bit_q      <= bit_d;
            sh_q       <= sh_d;
            mask_q     <= mask_d;
            nack_q     <= nack_d;
            scl_q      <= scl_d;
            oe_q       <= oe_d;
            sda_sync_q <= {sda_sync_q[0], sda_i};
        end
    end

endmodule

// File: rtl/sccb_cfg_seq.sv
// SCCB register-table sequencer: walks the init table, handles delays, end mark and NACK.
// Optional per-entry NACK retry is enabled by defining SCCB_CFG_RETRY_EN.
//
// state   | meaning
// IDLE    | after reset, waiting for auto start or iStart
// FETCH   | table address driven, data latched on second cycle
// DECODE  | classify entry: end mark, delay, or register write
// START   | bit engine generating START condition
// XFER    | bit engine shifting the 27-bit frame
// STOP    | bit engine generating STOP condition
// GAP     | inter-transaction idle; result evaluated at its end
// DELAY   | millisecond wait requested by the table
// DONE    | table finished, waiting for iStart
// ERROR   | NACK abort, waiting for iStart
module sccb_cfg_seq
    import sccb_cfg_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 25_000_000,
    parameter int unsigned I2C_FREQ   = 100_000,
    parameter logic [7:0]  SLAVE_ADDR = 8'h42,
    parameter int unsigned LUT_SIZE   = 164,
    parameter int unsigned AUTO_START = 1,
    parameter int unsigned MAX_RETRY  = 3
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic        iStart,
    output logic [15:0] oLUT_ADDR,
    input  logic [15:0] iLUT_DATA,
    output logic        oSCL,
    output logic        oSDA_OE,
    input  logic        iSDA,
    output logic        oBusy,
    output logic        oDone,
    output logic        oError,
    output logic [15:0] oErrIndex
);

`ifdef SCCB_CFG_RETRY_EN
    localparam bit RETRY_ON = 1'b1;
`else
    localparam bit RETRY_ON = 1'b0;
`endif

    localparam logic [7:0]  RETRY_LIM = RETRY_ON ? 8'(MAX_RETRY) : 8'd0;
    localparam logic [31:0] DLY_UNIT  = 32'(CLK_FREQ / 1000);
    localparam logic [15:0] LAST_IDX  = 16'(LUT_SIZE - 1);

    seq_state_t  state_q, state_d;
    logic [15:0] idx_q, idx_d;
    logic [15:0] data_q, data_d;
    logic [31:0] dly_q, dly_d;
    logic [7:0]  retry_q, retry_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [15:0] eidx_q, eidx_d;
    logic        auto_q, auto_d;
    logic        fwait_q, fwait_d;
    logic        go;
    logic        advance;
    phase_t      eng_phase;
    logic        eng_done;
    logic        eng_nack;

    sccb_bit_engine #(
        .CLK_FREQ (CLK_FREQ),
        .I2C_FREQ (I2C_FREQ)
    ) u_engine (
        .iCLK     (iCLK),
        .iRST_N   (iRST_N),
        .go_i     (go),
        .addr_i   (SLAVE_ADDR),
        .reg_i    (data_q[15:8]),
        .val_i    (data_q[7:0]),
        .sda_i    (iSDA),
        .scl_o    (oSCL),
        .sda_oe_o (oSDA_OE),
        .phase_o  (eng_phase),
        .done_o   (eng_done),
        .nack_o   (eng_nack)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        dly_d   = dly_q;
        retry_d = retry_q;
        done_d  = done_q;
        err_d   = err_q;
        eidx_d  = eidx_q;
        auto_d  = auto_q;
        fwait_d = fwait_q;
        go      = 1'b0;
        advance = 1'b0;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (iStart || auto_q) begin
                    state_d = S_FETCH;
                    idx_d   = 16'd0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    auto_d  = 1'b0;
                    fwait_d = 1'b0;
                    retry_d = 8'd0;
                end
            end
            S_FETCH: begin
                if (!fwait_q) begin
                    fwait_d = 1'b1;
                end else begin
                    fwait_d = 1'b0;
                    data_d  = iLUT_DATA;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (data_q == END_MARK) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else if (data_q[15:8] == DELAY_TAG) begin
                    dly_d   = 32'(data_q[7:0]) * DLY_UNIT;
                    state_d = S_DELAY;
                end else begin
                    go      = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: if (eng_phase == PH_XFER) state_d = S_XFER;
            S_XFER:  if (eng_phase == PH_STOP) state_d = S_STOP;
            S_STOP:  if (eng_phase == PH_GAP)  state_d = S_GAP;
            S_GAP: begin
                if (eng_done) begin
                    if (!eng_nack) begin
                        advance = 1'b1;
                    end else if (retry_q < RETRY_LIM) begin
                        retry_d = retry_q + 8'd1;
                        go      = 1'b1;
                        state_d = S_START;
                    end else begin
                        state_d = S_ERROR;
                        err_d   = 1'b1;
                        eidx_d  = idx_q;
                    end
                end
            end
            S_DELAY: begin
                // Zero-length delays still spend one cycle here.
                if (dly_q <= 32'd1) advance = 1'b1;
                else                dly_d   = dly_q - 32'd1;
            end
            default: state_d = S_IDLE;
        endcase

        if (advance) begin
            if (idx_q == LAST_IDX) begin
                state_d = S_DONE;
                done_d  = 1'b1;
            end else begin
                idx_d   = idx_q + 16'd1;
                state_d = S_FETCH;
                retry_d = 8'd0;
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q <= S_IDLE;
            idx_q   <= 16'd0;
            data_q  <= 16'd0;
            dly_q   <= 32'd0;
            retry_q <= 8'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            eidx_q  <= 16'd0;
            auto_q  <= (AUTO_START != 0);
            fwait_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            dly_q   <= dly_d;
            retry_q <= retry_d;
            done_q  <= done_d;
            err_q   <= err_d;
            eidx_q  <= eidx_d;
            auto_q  <= auto_d;
            fwait_q <= fwait_d;
        end
    end

    assign oLUT_ADDR = idx_q;
    assign oBusy     = !(state_q inside {S_IDLE, S_DONE, S_ERROR});
    assign oDone     = done_q;
    assign oError    = err_q;
    assign oErrIndex = eidx_q;

endmodule
